// File: rtl/cpu_mem_bridge_if.sv
// CPU-facing bus of the memory bridge: instruction-fetch channel plus data load/store channel.
// The CPU side uses the master modport; the bridge uses the slave modport.
interface cpu_mem_bridge_if;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;

    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    modport master (
        output PC, Inst_Req_Valid, Inst_Ready,
        output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        input  Inst_Req_Ready, Instruction, Inst_Valid,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ready,
        input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        output Inst_Req_Ready, Instruction, Inst_Valid,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Merges the CPU fetch and load/store channels onto one single-ported word SRAM,
// with one transaction in flight and a held response register.
module cpu_mem_bridge #(
    parameter int MEM_AW = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_mem_bridge_if.slave   cpu,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              proto_err
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KIND_INST  = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         resp_q, resp_d;
    logic                mem_en_q, mem_en_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic                inst_valid_q, inst_valid_d;
    logic                rd_valid_q, rd_valid_d;
    logic                proto_err_q, proto_err_d;

    logic                data_req_s;
    logic                data_acc_s;
    logic                inst_acc_s;
    logic                resp_take_s;
    logic                unused_s;

    // Data requests win over fetches; gating with rst_n keeps the readies low during reset.
    assign data_req_s  = cpu.MemRead | cpu.MemWrite;
    assign data_acc_s  = rst_n & (state_q == ST_IDLE) & data_req_s;
    assign inst_acc_s  = rst_n & (state_q == ST_IDLE) & cpu.Inst_Req_Valid & ~data_req_s;
    assign resp_take_s = ((kind_q == KIND_INST) & cpu.Inst_Ready) |
                         ((kind_q == KIND_LOAD) & cpu.Read_data_Ready);

    // Address bits above the SRAM and the byte offset alias and are intentionally dropped.
    assign unused_s = ^{cpu.PC[31:MEM_AW+2], cpu.PC[1:0],
                        cpu.Address[31:MEM_AW+2], cpu.Address[1:0]};

    assign cpu.Mem_Req_Ready   = data_acc_s;
    assign cpu.Inst_Req_Ready  = inst_acc_s;
    assign cpu.Instruction     = resp_q;
    assign cpu.Read_data       = resp_q;
    assign cpu.Inst_Valid      = inst_valid_q;
    assign cpu.Read_data_Valid = rd_valid_q;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign proto_err = proto_err_q;

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 4'b0000;
        inst_valid_d = inst_valid_q;
        rd_valid_d   = rd_valid_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (data_acc_s) begin
                    addr_d  = cpu.Address[MEM_AW+1:2];
                    wdata_d = cpu.Write_data;
                    state_d = ST_ISSUE;
                    if (cpu.MemWrite) begin
                        // A simultaneous read is dropped; the store still goes ahead.
                        kind_d      = KIND_STORE;
                        mem_en_d    = |cpu.Write_strb;
                        mem_we_d    = cpu.Write_strb;
                        proto_err_d = proto_err_q | cpu.MemRead;
                    end else begin
                        kind_d   = KIND_LOAD;
                        mem_en_d = 1'b1;
                    end
                end else if (inst_acc_s) begin
                    kind_d   = KIND_INST;
                    addr_d   = cpu.PC[MEM_AW+1:2];
                    mem_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (kind_q == KIND_STORE) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    resp_d       = mem_rdata;
                    inst_valid_d = (kind_q == KIND_INST);
                    rd_valid_d   = (kind_q == KIND_LOAD);
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (resp_take_s) begin
                    inst_valid_d = 1'b0;
                    rd_valid_d   = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                inst_valid_d = 1'b0;
                rd_valid_d   = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_INST;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            cnt_q        <= 3'd0;
            resp_q       <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            inst_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            inst_valid_q <= inst_valid_d;
            rd_valid_q   <= rd_valid_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: one RD_LAT=1 and one RD_LAT=3 instance, each with its
// own behavioural SRAM; sel chooses which instance receives stimulus and is observed.
module tb_cpu_mem_bridge;
    localparam int AW = 14;
    localparam int KF = 0;
    localparam int KL = 1;
    localparam int KS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst3_n, sel;
    logic [31:0] pc, address, wdata;
    logic [3:0]  strb;
    logic        irv, iready, memwrite, memread, rready;

    int checks = 0;
    int errors = 0;

    cpu_mem_bridge_if b1();
    cpu_mem_bridge_if b3();

    assign b1.PC              = sel ? 32'd0 : pc;
    assign b1.Inst_Req_Valid  = sel ? 1'b0  : irv;
    assign b1.Inst_Ready      = sel ? 1'b0  : iready;
    assign b1.Address         = sel ? 32'd0 : address;
    assign b1.MemWrite        = sel ? 1'b0  : memwrite;
    assign b1.Write_data      = sel ? 32'd0 : wdata;
    assign b1.Write_strb      = sel ? 4'd0  : strb;
    assign b1.MemRead         = sel ? 1'b0  : memread;
    assign b1.Read_data_Ready = sel ? 1'b0  : rready;

    assign b3.PC              = sel ? pc       : 32'd0;
    assign b3.Inst_Req_Valid  = sel ? irv      : 1'b0;
    assign b3.Inst_Ready      = sel ? iready   : 1'b0;
    assign b3.Address         = sel ? address  : 32'd0;
    assign b3.MemWrite        = sel ? memwrite : 1'b0;
    assign b3.Write_data      = sel ? wdata    : 32'd0;
    assign b3.Write_strb      = sel ? strb     : 4'd0;
    assign b3.MemRead         = sel ? memread  : 1'b0;
    assign b3.Read_data_Ready = sel ? rready   : 1'b0;

    logic          m1_en, m3_en, perr1, perr3;
    logic [3:0]    m1_we, m3_we;
    logic [AW-1:0] m1_addr, m3_addr;
    logic [31:0]   m1_wdata, m3_wdata, m1_rdata, m3_rdata, p3_0, p3_1;
    logic [31:0]   mem1 [0:255];
    logic [31:0]   mem3 [0:255];

    cpu_mem_bridge #(.MEM_AW(AW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst1_n), .cpu(b1),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .proto_err(perr1)
    );

    cpu_mem_bridge #(.MEM_AW(AW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst3_n), .cpu(b3),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
        .mem_wdata(m3_wdata), .mem_rdata(m3_rdata), .proto_err(perr3)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // SRAM models: byte-masked write, read data RD_LAT cycles after mem_en.
    always @(posedge clk) begin
        if (m1_en) mem1[m1_addr[7:0]] <= merge(mem1[m1_addr[7:0]], m1_wdata, m1_we);
        m1_rdata <= m1_en ? mem1[m1_addr[7:0]] : 32'd0;
    end

    always @(posedge clk) begin
        if (m3_en) mem3[m3_addr[7:0]] <= merge(mem3[m3_addr[7:0]], m3_wdata, m3_we);
        p3_0     <= m3_en ? mem3[m3_addr[7:0]] : 32'd0;
        p3_1     <= p3_0;
        m3_rdata <= p3_1;
    end

    logic          o_irr, o_mrr, o_iv, o_rv, o_men, o_perr;
    logic [31:0]   o_ins, o_rdd;
    logic [3:0]    o_mwe;
    logic [AW-1:0] o_maddr;

    assign o_irr   = sel ? b3.Inst_Req_Ready  : b1.Inst_Req_Ready;
    assign o_mrr   = sel ? b3.Mem_Req_Ready   : b1.Mem_Req_Ready;
    assign o_iv    = sel ? b3.Inst_Valid      : b1.Inst_Valid;
    assign o_rv    = sel ? b3.Read_data_Valid : b1.Read_data_Valid;
    assign o_ins   = sel ? b3.Instruction     : b1.Instruction;
    assign o_rdd   = sel ? b3.Read_data       : b1.Read_data;
    assign o_men   = sel ? m3_en   : m1_en;
    assign o_mwe   = sel ? m3_we   : m1_we;
    assign o_maddr = sel ? m3_addr : m1_addr;
    assign o_perr  = sel ? perr3   : perr1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s (lat%0d) t=%0t: got 0x%08h expected 0x%08h",
                     name, sel ? 3 : 1, $time, act, exp_v);
        end
    endtask

    task automatic go_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ea;
        logic [31:0] ed;
        int          hold;
    } vec_t;

    // One full transaction; starts and ends just after a rising edge.
    task automatic txn(input vec_t v);
        int   lat;
        logic rd, exp_en;
        lat    = sel ? 3 : 1;
        rd     = (v.kind != KS);
        exp_en = rd || (v.be != 4'd0);
        pc = v.addr; address = v.addr; wdata = v.wd; strb = v.be;
        irv = (v.kind == KF); memread = (v.kind == KL); memwrite = (v.kind == KS);
        @(negedge clk);
        chk("inst_req_ready", {31'd0, o_irr}, {31'd0, v.kind == KF});
        chk("mem_req_ready",  {31'd0, o_mrr}, {31'd0, v.kind != KF});
        go_cycle();
        irv = 1'b0; memread = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        chk("mem_en_issue", {31'd0, o_men}, {31'd0, exp_en});
        if (exp_en) begin
            chk("mem_addr", {18'd0, o_maddr}, v.ea);
            chk("mem_we",   {28'd0, o_mwe},   rd ? 32'd0 : {28'd0, v.be});
        end
        go_cycle();
        if (rd) begin
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                chk("valid_early", {30'd0, o_iv, o_rv}, 32'd0);
                go_cycle();
            end
            @(negedge clk);
            chk("resp_valid", {30'd0, o_iv, o_rv}, (v.kind == KF) ? 32'd2 : 32'd1);
            chk("resp_data_inst", o_ins, v.ed);
            chk("resp_data_load", o_rdd, v.ed);
            for (int h = 0; h < v.hold; h++) begin
                if (v.kind == KF) rready = 1'b1; else iready = 1'b1;
                go_cycle();
                @(negedge clk);
                chk("resp_hold_valid", {30'd0, o_iv, o_rv}, (v.kind == KF) ? 32'd2 : 32'd1);
                chk("resp_hold_data", (v.kind == KF) ? o_ins : o_rdd, v.ed);
            end
            rready = (v.kind == KL);
            iready = (v.kind == KF);
            go_cycle();
            rready = 1'b0; iready = 1'b0;
            @(negedge clk);
            chk("resp_released", {30'd0, o_iv, o_rv}, 32'd0);
            go_cycle();
        end
    endtask

    vec_t vecs [11];
    vec_t v;

    initial begin
        vecs[0]  = '{KS, 32'h0000_0010, 32'h0050_0093, 4'b1111, 32'd4, 32'd0,         0};
        vecs[1]  = '{KF, 32'h0000_0012, 32'd0,         4'b0000, 32'd4, 32'h0050_0093, 3};
        vecs[2]  = '{KS, 32'h0000_0020, 32'h0000_0000, 4'b1111, 32'd8, 32'd0,         0};
        vecs[3]  = '{KS, 32'h0000_0020, 32'h00AB_0000, 4'b0100, 32'd8, 32'd0,         0};
        vecs[4]  = '{KL, 32'h0000_0020, 32'd0,         4'b0000, 32'd8, 32'h00AB_0000, 1};
        vecs[5]  = '{KS, 32'h0000_0024, 32'h1122_3344, 4'b1111, 32'd9, 32'd0,         0};
        vecs[6]  = '{KS, 32'h0000_0024, 32'h0000_BEEF, 4'b0011, 32'd9, 32'd0,         0};
        vecs[7]  = '{KS, 32'h0000_0024, 32'hFFFF_FFFF, 4'b0000, 32'd9, 32'd0,         0};
        vecs[8]  = '{KL, 32'h0000_0024, 32'd0,         4'b0000, 32'd9, 32'h1122_BEEF, 0};
        vecs[9]  = '{KF, 32'hFFFF_0024, 32'd0,         4'b0000, 32'd9, 32'h1122_BEEF, 0};
        vecs[10] = '{KL, 32'h0001_0010, 32'd0,         4'b0000, 32'd4, 32'h0050_0093, 0};

        sel = 1'b0; rst1_n = 1'b0; rst3_n = 1'b0;
        pc = 32'd0; address = 32'd0; wdata = 32'd0; strb = 4'd0;
        irv = 1'b0; iready = 1'b0; memwrite = 1'b0; memread = 1'b0; rready = 1'b0;

        // Reset state of both builds
        for (int s = 0; s < 2; s++) begin
            #2;
            sel = s[0];
            #1;
            chk("rst_mem_en", {31'd0, o_men}, 32'd0);
            chk("rst_mem_we", {28'd0, o_mwe}, 32'd0);
            chk("rst_mem_addr", {18'd0, o_maddr}, 32'd0);
            chk("rst_valids", {30'd0, o_iv, o_rv}, 32'd0);
            chk("rst_resp", o_rdd | o_ins, 32'd0);
            chk("rst_proto_err", {31'd0, o_perr}, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1; rst3_n = 1'b1;
        go_cycle();

        for (int i = 0; i < 11; i++) txn(vecs[i]);

        // Contention: load wins, fetch waits until the cycle after the load handshake
        irv = 1'b1; pc = 32'h10; memread = 1'b1; address = 32'h20;
        @(negedge clk);
        chk("cont_mem_ready", {31'd0, o_mrr}, 32'd1);
        chk("cont_inst_ready", {31'd0, o_irr}, 32'd0);
        go_cycle();
        memread = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("cont_inst_blocked", {31'd0, o_irr}, 32'd0);
            go_cycle();
        end
        @(negedge clk);
        chk("cont_load_valid", {31'd0, o_rv}, 32'd1);
        chk("cont_load_data", o_rdd, 32'h00AB_0000);
        chk("cont_inst_blocked_hs", {31'd0, o_irr}, 32'd0);
        rready = 1'b1;
        go_cycle();
        rready = 1'b0;
        @(negedge clk);
        chk("cont_inst_ready_after", {31'd0, o_irr}, 32'd1);
        chk("cont_load_dropped", {31'd0, o_rv}, 32'd0);
        go_cycle();
        irv = 1'b0;
        @(negedge clk);
        chk("cont_fetch_issue", {31'd0, o_men}, 32'd1);
        chk("cont_fetch_addr", {18'd0, o_maddr}, 32'd4);
        go_cycle();
        go_cycle();
        @(negedge clk);
        chk("cont_fetch_valid", {31'd0, o_iv}, 32'd1);
        chk("cont_fetch_data", o_ins, 32'h0050_0093);
        iready = 1'b1;
        go_cycle();
        iready = 1'b0;
        go_cycle();

        // Protocol error: read+write becomes a store and sets a sticky flag
        memread = 1'b1; memwrite = 1'b1; address = 32'h30; wdata = 32'hCAFE_F00D; strb = 4'b1111;
        @(negedge clk);
        chk("perr_mem_ready", {31'd0, o_mrr}, 32'd1);
        chk("perr_before", {31'd0, o_perr}, 32'd0);
        go_cycle();
        memread = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        chk("perr_store_we", {28'd0, o_mwe}, 32'hF);
        chk("perr_store_addr", {18'd0, o_maddr}, 32'd12);
        chk("perr_set", {31'd0, o_perr}, 32'd1);
        go_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("perr_no_read_valid", {31'd0, o_rv}, 32'd0);
            go_cycle();
        end
        for (int i = 0; i < 10; i++) begin
            v = '{KL, 32'h30, 32'd0, 4'd0, 32'd12, 32'hCAFE_F00D, 0};
            txn(v);
            chk("perr_sticky", {31'd0, o_perr}, 32'd1);
        end

        // Reset during ISSUE clears outputs without a clock edge
        memread = 1'b1; address = 32'h10;
        go_cycle();
        memread = 1'b0;
        @(negedge clk);
        chk("rst_issue_pre_en", {31'd0, o_men}, 32'd1);
        rst1_n = 1'b0;
        #1;
        chk("rst_issue_en", {31'd0, o_men}, 32'd0);
        chk("rst_issue_addr", {18'd0, o_maddr}, 32'd0);
        chk("rst_issue_perr", {31'd0, o_perr}, 32'd0);
        go_cycle();
        @(negedge clk);
        rst1_n = 1'b1;
        go_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_issue_quiet", {29'd0, o_iv, o_rv, o_men}, 32'd0);
            go_cycle();
        end

        // Reset during RESP drops the valid immediately
        memread = 1'b1; address = 32'h10;
        go_cycle();
        memread = 1'b0;
        go_cycle();
        go_cycle();
        @(negedge clk);
        chk("rst_resp_pre_valid", {31'd0, o_rv}, 32'd1);
        rst1_n = 1'b0;
        #1;
        chk("rst_resp_valid", {31'd0, o_rv}, 32'd0);
        chk("rst_resp_data", o_rdd, 32'd0);
        go_cycle();
        @(negedge clk);
        rst1_n = 1'b1;
        go_cycle();
        v = '{KF, 32'h10, 32'd0, 4'd0, 32'd4, 32'h0050_0093, 0};
        txn(v);

        // RD_LAT=3 build
        sel = 1'b1;
        go_cycle();
        v = '{KS, 32'h40, 32'hDEAD_BEEF, 4'b1111, 32'd16, 32'd0, 0};
        txn(v);
        v = '{KL, 32'h40, 32'd0, 4'd0, 32'd16, 32'hDEAD_BEEF, 1};
        txn(v);
        v = '{KS, 32'h40, 32'h0000_0000, 4'b0000, 32'd16, 32'd0, 0};
        txn(v);
        @(negedge clk);
        chk("lat3_noop_no_en", {31'd0, o_men}, 32'd0);
        go_cycle();
        v = '{KL, 32'h40, 32'd0, 4'd0, 32'd16, 32'hDEAD_BEEF, 0};
        txn(v);

        // Reset in WAIT: no response may surface after release
        memread = 1'b1; address = 32'h40;
        go_cycle();
        memread = 1'b0;
        go_cycle();
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("rst_wait_en", {31'd0, o_men}, 32'd0);
        chk("rst_wait_valid", {30'd0, o_iv, o_rv}, 32'd0);
        go_cycle();
        @(negedge clk);
        rst3_n = 1'b1;
        go_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_wait_quiet", {29'd0, o_iv, o_rv, o_men}, 32'd0);
            go_cycle();
        end
        v = '{KL, 32'h40, 32'd0, 4'd0, 32'd16, 32'hDEAD_BEEF, 0};
        txn(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Memory-side companion to the multicycle CPU. It merges the CPU's instruction-fetch channel and its data load/store channel onto one single-ported synchronous word SRAM, keeping at most one transaction in flight. Read data is held in a response register until the CPU's ready handshake completes. The CPU ports connect 1:1 to the same-named CPU signals; the mem_* ports connect to the SRAM macro.

## Interface
- MEM_AW, 14: SRAM word-address width (2^MEM_AW words of 32 bits).
- RD_LAT, 1: SRAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserting it clears all state immediately.
- PC  in  32  fetch byte address; bits [1:0] are ignored.
- Inst_Req_Valid  in  1  fetch request.
- Inst_Req_Ready  out  1  fetch accepted.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  fetch response valid.
- Inst_Ready  in  1  CPU takes fetch response.
- Address  in  32  data byte address, word aligned.
- MemWrite  in  1  store request.
- Write_data  in  32  store data, already lane-aligned.
- Write_strb  in  4  byte enables.
- MemRead  in  1  load request.
- Mem_Req_Ready  out  1  data request accepted.
- Read_data  out  32  loaded word.
- Read_data_Valid  out  1  load response valid.
- Read_data_Ready  in  1  CPU takes load response.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  4  SRAM byte write enables; 0 means read.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid RD_LAT cycles after mem_en.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: Mem_Req_Ready = MemRead | MemWrite. Inst_Req_Ready = Inst_Req_Valid & ~MemRead & ~MemWrite, so data requests have fixed priority. On acceptance, the block latches the request:
  - address bits [MEM_AW+1:2]; upper bits alias and are not checked;
  - kind (inst/load/store);
  - Write_data and Write_strb.
  - It then moves to ISSUE.
- ISSUE (1 cycle): mem_en=1 and mem_addr=latched address.
  - Store: mem_we=latched strobe, mem_wdata=latched data; next state IDLE.
  - Store with Write_strb=0: mem_en stays 0 (no-op); next state IDLE.
  - Read: mem_we=0; WAIT counter loads RD_LAT; next state WAIT.
- WAIT: counter decrements each cycle. When it reaches 1, mem_rdata is captured into the response register and the state moves to RESP.
- RESP: Inst_Valid=1 for a fetch, or Read_data_Valid=1 for a load. Instruction/Read_data come from the response register and stay stable. Exit to IDLE on the cycle the matching Ready is 1. The opposite Ready is ignored.
- MemRead and MemWrite both 1 in IDLE: accept as a store, ignore the read, set proto_err=1. proto_err is cleared only by reset.
- Outside IDLE, Inst_Req_Ready=0 and Mem_Req_Ready=0. Requests raised meanwhile wait; none are dropped.
- Instruction and Read_data are both driven from the single response register. Only the valid flag is kind-specific.

## Timing
- Reset values: all outputs 0, state IDLE, response register 0, proto_err 0.
- The CPU-side request readies are combinational from the inputs in IDLE. All other outputs are registered.
- Request accepted in cycle A:
  - ISSUE is in cycle A+1.
  - SRAM data is sampled at the end of cycle A+1+RD_LAT.
  - Response valid from cycle A+2+RD_LAT.
- With RD_LAT=1, fetch/load response latency is 3 cycles. Store occupancy is 2 cycles (A, A+1); the next request can be accepted in A+2.
- The earliest re-acceptance is the cycle after the RESP handshake. There is no same-cycle RESP→accept path.
- Reset asserted in any state forces outputs to their reset values without waiting for a clock edge. Any in-flight transaction is discarded. No stale Valid may appear after release.

## Test plan
- Fetch, RD_LAT=1: preload mem[4]=0x00500093; PC=0x00000012 accepted in cycle A → mem_addr=4 in A+1; Inst_Valid=1 with Instruction=0x00500093 from A+3; hold Inst_Ready=0 for 3 cycles → data stable, Inst_Valid held; Inst_Ready=1 → IDLE next cycle.
- Store byte: Address=0x20, Write_strb=4'b0100, Write_data=0x00AB0000 → Mem_Req_Ready=1 in A; mem_en=1, mem_we=4'b0100, mem_addr=8 in A+1; a subsequent load of 0x20 returns 0x00AB0000 in lane 2 only.
- Contention: Inst_Req_Valid and MemRead both 1 in IDLE → Mem_Req_Ready=1, Inst_Req_Ready=0; the fetch is accepted only in the cycle after the Read_data_Ready handshake.
- Protocol error: MemRead=MemWrite=1 → a store is performed, no Read_data_Valid appears, proto_err=1 and stays 1 through 10 further transactions.
- Reset in WAIT: drop rst_n one cycle after ISSUE → mem_en, Inst_Valid and Read_data_Valid are 0 asynchronously; after release, state is IDLE and no response appears.
- RD_LAT=3 build: load accepted in A → Read_data_Valid first high in cycle A+5 with the correct word; the strb=0 store produces no mem_en pulse.
